rob_multiport: RTL and testbench
================================

Name: rob_multiport

Overview:
- Parametrised next-generation reorder buffer: in-order retirement of up to DEPTH speculative instructions.
- Accepts completions from WB_PORTS result buses.
- Offers QRY_PORTS combinational operand-forwarding lookups.
- Issues single-cycle commit, branch-resolve, JALR-redirect and flush pulses to the register file, RS, LSB and instruction unit.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- IDX_W, 4, entry index width; equals log2(DEPTH).
- WB_PORTS, 2, number of writeback channels (RS, LSB, ...).
- QRY_PORTS, 2, number of operand lookup ports.

Ports:
- clk_in  in  1  clock; single clock domain.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; when low all state and outputs hold.
- iss_valid  in  1  issue request.
- iss_ready  out  1  = !full && !flush_out (combinational).
- iss_cls  in  3  op class: ALU/LOAD/STORE/BRANCH/JALR.
- iss_rd  in  5  destination register.
- iss_pc  in  32  instruction address.
- iss_is_c  in  1  compressed instruction; link/fallthrough uses +2, else +4.
- iss_imm  in  32  branch offset.
- iss_pred  in  1  predicted taken.
- iss_id  out  IDX_W  tail index assigned to this issue.
- wb_valid  in  WB_PORTS  per-channel completion.
- wb_id  in  WB_PORTS*IDX_W  packed entry ids.
- wb_val  in  WB_PORTS*32  packed results; for branches, bit0 = taken.
- qry_id  in  QRY_PORTS*IDX_W  lookup ids.
- qry_ready  out  QRY_PORTS  entry busy and done.
- qry_val  out  QRY_PORTS*32  entry result.
- head_out  out  IDX_W  current head index.
- count_out  out  IDX_W+1  current occupancy.
- cmt_valid  out  1  reg-writing commit pulse.
- cmt_rd  out  5  destination register.
- cmt_id  out  IDX_W  committed entry id.
- cmt_val  out  32  value to write.
- st_cmt  out  1  store commit pulse to LSB.
- br_valid  out  1  branch resolved pulse.
- br_taken  out  1  actual branch outcome.
- br_correct  out  1  prediction matched.
- br_pc  out  32  branch address.
- flush_out  out  1  misprediction/JALR flush pulse.
- redirect_pc  out  32  new fetch PC, valid with flush_out or jalr_valid.
- jalr_valid  out  1  JALR resolved (fetch stall end).

Behaviour:
- Reset, or flush_out high at a clock edge:
  - head = tail = count = 0; all busy/done bits cleared.
  - All registered outputs 0; flush_out deasserts.
  - Issue is ignored during the flush cycle.
- Issue, when iss_valid && iss_ready:
  - Entry[tail] set busy=1, done=0, all fields latched.
  - tail = (tail+1) mod DEPTH.
  - iss_id = tail before increment.
- Writeback, per channel k with wb_valid[k]:
  - Entry[wb_id] takes done=1 and res=wb_val.
  - Writeback to a non-busy entry is ignored.
  - Two channels to the same id: the higher k wins.
- Query is purely combinational from registered state:
  - qry_ready = busy && done.
  - Same-cycle writeback is not bypassed.
- Commit: when entry[head] is busy && done, retire it in one cycle.
  - head advances mod DEPTH; busy clears.
  - ALU/LOAD: cmt_valid=1, cmt_val=res.
  - STORE: st_cmt=1, cmt_valid=0.
  - BRANCH: br_valid=1, br_taken=res[0], br_correct=(res[0]==pred).
    - On mismatch: flush_out=1; redirect_pc = taken ? pc+imm : pc+(is_c?2:4).
  - JALR: cmt_valid=1, cmt_val=pc+(is_c?2:4), jalr_valid=1, redirect_pc=res & ~1.
    - No flush: fetch was stalled.
  - All commit outputs are registered, one-cycle pulses; they are 0 when nothing retires.
- Writeback to head on cycle N retires on N+1; outputs are visible on N+2.
- count:
  - Simultaneous issue and retire leaves count unchanged.
  - full = (count == DEPTH); empty = (count == 0).
  - No slack entries are reserved; iss_ready is exact.
- Wrap-around: head and tail wrap independently; full vs empty is distinguished by count, not pointer equality.
- rdy_in low:
  - No issue, writeback, retire or counter update.
  - Pulses hold their value; consumers gate with rdy_in.
- A flush does not cancel the commit of the mispredicted branch itself; its br_valid pulse coincides with flush_out.

Optional Feature:
- ROB_PERF_CNT_EN defined: adds 32-bit outputs perf_commits, perf_branches and perf_mispred.
  - Each increments on the corresponding commit pulse and wraps at 2^32.
  - Cleared only by rst_in, not by flush.
- Undefined: no counters, no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package/const header: op-class codes (CLS_ALU=0, CLS_LOAD=1, CLS_STORE=2, CLS_BRANCH=3, CLS_JALR=4), default DEPTH/IDX_W.
- One sub-module: rob_wb_merge, which resolves the WB_PORTS writes into per-entry done/res write-enables with higher-port priority.

Test Plan:
- Reset, then issue 3 ALU ops (rd 1,2,3) and write back out of order (ids 2,0,1 with values 0x30,0x10,0x20) -> cmt_valid pulses in id order 0,1,2 with cmt_val 0x10,0x20,0x30.
- Issue 16 entries with none written back -> iss_ready=0 and count_out=16; a 17th iss_valid is ignored. Then complete the head -> iss_ready=1, and the next issue gets iss_id=0 (wrap).
- Branch at pc 0x100 with imm 0x40, pred=0, written back with taken=1 -> br_valid=1, br_correct=0, flush_out=1, redirect_pc=0x140. Next cycle count_out=0.
- Compressed JALR at pc 0x200 with res 0x305 -> cmt_val=0x202, jalr_valid=1, redirect_pc=0x304, flush_out=0.
- Both wb channels write id 5 with 0xA and 0xB, then query id 5 -> qry_ready=1, qry_val=0xB.
- Hold rdy_in low 3 cycles with issue and writeback asserted -> head_out, count_out and all outputs unchanged.

Source files
------------

// File: rtl/rob_multiport_pkg.sv
// Shared definitions for the rob_multiport reorder buffer: op-class codes, default sizing
// and the link-address helper.
package rob_multiport_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_IDX_W = 4;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JALR   = 3'd4
  } op_cls_e;

  // Fall-through / link address of an instruction.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic is_c);
    return pc + (is_c ? 32'd2 : 32'd4);
  endfunction

endpackage

// File: rtl/rob_multiport_if.sv
// Issue, writeback, query and commit bundle of rob_multiport.
// Defining ROB_PERF_CNT_EN adds the perf_commits/perf_branches/perf_mispred outputs.
interface rob_multiport_if #(
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned WB_PORTS  = 2,
  parameter int unsigned QRY_PORTS = 2
);
  logic                       iss_valid;
  logic                       iss_ready;
  logic [2:0]                 iss_cls;
  logic [4:0]                 iss_rd;
  logic [31:0]                iss_pc;
  logic                       iss_is_c;
  logic [31:0]                iss_imm;
  logic                       iss_pred;
  logic [IDX_W-1:0]           iss_id;

  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*IDX_W-1:0]  wb_id;
  logic [WB_PORTS*32-1:0]     wb_val;

  logic [QRY_PORTS*IDX_W-1:0] qry_id;
  logic [QRY_PORTS-1:0]       qry_ready;
  logic [QRY_PORTS*32-1:0]    qry_val;

  logic [IDX_W-1:0]           head_out;
  logic [IDX_W:0]             count_out;

  logic                       cmt_valid;
  logic [4:0]                 cmt_rd;
  logic [IDX_W-1:0]           cmt_id;
  logic [31:0]                cmt_val;
  logic                       st_cmt;
  logic                       br_valid;
  logic                       br_taken;
  logic                       br_correct;
  logic [31:0]                br_pc;
  logic                       flush_out;
  logic [31:0]                redirect_pc;
  logic                       jalr_valid;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]                perf_commits;
  logic [31:0]                perf_branches;
  logic [31:0]                perf_mispred;
`endif

  modport master (
    output iss_valid, iss_cls, iss_rd, iss_pc, iss_is_c, iss_imm, iss_pred,
    output wb_valid, wb_id, wb_val, qry_id,
    input  iss_ready, iss_id, qry_ready, qry_val, head_out, count_out,
    input  cmt_valid, cmt_rd, cmt_id, cmt_val, st_cmt, br_valid, br_taken, br_correct, br_pc,
    input  flush_out, redirect_pc, jalr_valid
`ifdef ROB_PERF_CNT_EN
    , input perf_commits, perf_branches, perf_mispred
`endif
  );

  modport slave (
    input  iss_valid, iss_cls, iss_rd, iss_pc, iss_is_c, iss_imm, iss_pred,
    input  wb_valid, wb_id, wb_val, qry_id,
    output iss_ready, iss_id, qry_ready, qry_val, head_out, count_out,
    output cmt_valid, cmt_rd, cmt_id, cmt_val, st_cmt, br_valid, br_taken, br_correct, br_pc,
    output flush_out, redirect_pc, jalr_valid
`ifdef ROB_PERF_CNT_EN
    , output perf_commits, perf_branches, perf_mispred
`endif
  );

endinterface

// File: rtl/rob_wb_merge.sv
// Folds the writeback channels into per-entry done/result write enables; the highest
// channel wins on a shared id, and writes to idle entries are dropped.
module rob_wb_merge #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned WB_PORTS = 2
) (
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0] wb_id,
  input  logic [WB_PORTS*32-1:0]    wb_val,
  input  logic [DEPTH-1:0]          busy,
  output logic [DEPTH-1:0]          wr_en,
  output logic [31:0]               wr_val [DEPTH]
);

  always_comb begin
    wr_en = '0;
    for (int e = 0; e < DEPTH; e++) begin
      wr_val[e] = '0;
    end
    // Ascending scan: a later channel overwrites an earlier one.
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k] && busy[wb_id[k*IDX_W +: IDX_W]]) begin
        wr_en[wb_id[k*IDX_W +: IDX_W]]  = 1'b1;
        wr_val[wb_id[k*IDX_W +: IDX_W]] = wb_val[k*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer with multi-port writeback, operand lookup and in-order registered commit.
// Optional ROB_PERF_CNT_EN adds commit/branch/mispredict counters.
module rob_multiport import rob_multiport_pkg::*; #(
  parameter int unsigned DEPTH     = ROB_DEPTH,
  parameter int unsigned IDX_W     = ROB_IDX_W,
  parameter int unsigned WB_PORTS  = 2,
  parameter int unsigned QRY_PORTS = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  rob_multiport_if.slave bus
);

  localparam logic [IDX_W:0]   FullCnt = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CntOne  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);

  logic [DEPTH-1:0] busy_q, done_q, is_c_q, pred_q;
  logic [2:0]       cls_q [DEPTH];
  logic [4:0]       rd_q  [DEPTH];
  logic [31:0]      pc_q  [DEPTH];
  logic [31:0]      imm_q [DEPTH];
  logic [31:0]      res_q [DEPTH];

  logic [IDX_W-1:0] head_q, tail_q;
  logic [IDX_W:0]   count_q, count_d;

  logic             cmt_valid_q, cmt_valid_d;
  logic [4:0]       cmt_rd_q, cmt_rd_d;
  logic [IDX_W-1:0] cmt_id_q, cmt_id_d;
  logic [31:0]      cmt_val_q, cmt_val_d;
  logic             st_cmt_q, st_cmt_d;
  logic             br_valid_q, br_valid_d;
  logic             br_taken_q, br_taken_d;
  logic             br_correct_q, br_correct_d;
  logic [31:0]      br_pc_q, br_pc_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             jalr_valid_q, jalr_valid_d;

  logic             issue, retire, full;
  logic [DEPTH-1:0] wb_en;
  logic [31:0]      wb_res [DEPTH];
  logic [31:0]      head_pc, head_res, head_link;
  logic             head_taken;
  logic [QRY_PORTS-1:0]    qry_ready;
  logic [QRY_PORTS*32-1:0] qry_val;

  rob_wb_merge #(
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .WB_PORTS (WB_PORTS)
  ) u_wb_merge (
    .wb_valid (bus.wb_valid),
    .wb_id    (bus.wb_id),
    .wb_val   (bus.wb_val),
    .busy     (busy_q),
    .wr_en    (wb_en),
    .wr_val   (wb_res)
  );

  assign full          = (count_q == FullCnt);
  assign bus.iss_ready = !full && !flush_q;
  assign issue         = rdy_in && bus.iss_valid && bus.iss_ready;
  // The flush cycle only clears state; nothing retires in it.
  assign retire        = rdy_in && !flush_q && busy_q[head_q] && done_q[head_q];

  assign head_pc    = pc_q[head_q];
  assign head_res   = res_q[head_q];
  assign head_taken = head_res[0];
  assign head_link  = next_pc(head_pc, is_c_q[head_q]);

  always_comb begin
    count_d = count_q;
    case ({issue, retire})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    cmt_valid_d   = 1'b0;
    cmt_rd_d      = '0;
    cmt_id_d      = '0;
    cmt_val_d     = '0;
    st_cmt_d      = 1'b0;
    br_valid_d    = 1'b0;
    br_taken_d    = 1'b0;
    br_correct_d  = 1'b0;
    br_pc_d       = '0;
    flush_d       = 1'b0;
    redirect_pc_d = '0;
    jalr_valid_d  = 1'b0;
    if (retire) begin
      cmt_id_d = head_q;
      case (cls_q[head_q])
        CLS_ALU, CLS_LOAD: begin
          cmt_valid_d = 1'b1;
          cmt_rd_d    = rd_q[head_q];
          cmt_val_d   = head_res;
        end
        CLS_STORE: st_cmt_d = 1'b1;
        CLS_BRANCH: begin
          br_valid_d   = 1'b1;
          br_taken_d   = head_taken;
          br_correct_d = (head_taken == pred_q[head_q]);
          br_pc_d      = head_pc;
          if (head_taken != pred_q[head_q]) begin
            flush_d       = 1'b1;
            redirect_pc_d = head_taken ? head_pc + imm_q[head_q] : head_link;
          end
        end
        CLS_JALR: begin
          // Fetch stalled behind the JALR, so a redirect is enough; no flush.
          cmt_valid_d   = 1'b1;
          cmt_rd_d      = rd_q[head_q];
          cmt_val_d     = head_link;
          jalr_valid_d  = 1'b1;
          redirect_pc_d = head_res & ~32'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && flush_q)) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      busy_q        <= '0;
      done_q        <= '0;
      cmt_valid_q   <= 1'b0;
      cmt_rd_q      <= '0;
      cmt_id_q      <= '0;
      cmt_val_q     <= '0;
      st_cmt_q      <= 1'b0;
      br_valid_q    <= 1'b0;
      br_taken_q    <= 1'b0;
      br_correct_q  <= 1'b0;
      br_pc_q       <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      jalr_valid_q  <= 1'b0;
    end else if (rdy_in) begin
      count_q       <= count_d;
      cmt_valid_q   <= cmt_valid_d;
      cmt_rd_q      <= cmt_rd_d;
      cmt_id_q      <= cmt_id_d;
      cmt_val_q     <= cmt_val_d;
      st_cmt_q      <= st_cmt_d;
      br_valid_q    <= br_valid_d;
      br_taken_q    <= br_taken_d;
      br_correct_q  <= br_correct_d;
      br_pc_q       <= br_pc_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      jalr_valid_q  <= jalr_valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_en[i]) begin
          done_q[i] <= 1'b1;
          res_q[i]  <= wb_res[i];
        end
      end
      if (retire) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= head_q + IdxOne;
      end
      if (issue) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        cls_q[tail_q]  <= bus.iss_cls;
        rd_q[tail_q]   <= bus.iss_rd;
        pc_q[tail_q]   <= bus.iss_pc;
        is_c_q[tail_q] <= bus.iss_is_c;
        imm_q[tail_q]  <= bus.iss_imm;
        pred_q[tail_q] <= bus.iss_pred;
        tail_q         <= tail_q + IdxOne;
      end
    end
  end

  // Lookups see registered state only; a same-cycle writeback is not forwarded.
  always_comb begin
    qry_ready = '0;
    qry_val   = '0;
    for (int p = 0; p < QRY_PORTS; p++) begin
      qry_ready[p]        = busy_q[bus.qry_id[p*IDX_W +: IDX_W]]
                            && done_q[bus.qry_id[p*IDX_W +: IDX_W]];
      qry_val[p*32 +: 32] = res_q[bus.qry_id[p*IDX_W +: IDX_W]];
    end
  end

  assign bus.qry_ready   = qry_ready;
  assign bus.qry_val     = qry_val;
  assign bus.iss_id      = tail_q;
  assign bus.head_out    = head_q;
  assign bus.count_out   = count_q;
  assign bus.cmt_valid   = cmt_valid_q;
  assign bus.cmt_rd      = cmt_rd_q;
  assign bus.cmt_id      = cmt_id_q;
  assign bus.cmt_val     = cmt_val_q;
  assign bus.st_cmt      = st_cmt_q;
  assign bus.br_valid    = br_valid_q;
  assign bus.br_taken    = br_taken_q;
  assign bus.br_correct  = br_correct_q;
  assign bus.br_pc       = br_pc_q;
  assign bus.flush_out   = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.jalr_valid  = jalr_valid_q;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commits_q, perf_branches_q, perf_mispred_q;

  // Survives flushes; only rst_in clears the counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_commits_q  <= '0;
      perf_branches_q <= '0;
      perf_mispred_q  <= '0;
    end else if (retire) begin
      perf_commits_q <= perf_commits_q + 32'd1;
      if (br_valid_d) begin
        perf_branches_q <= perf_branches_q + 32'd1;
      end
      if (flush_d) begin
        perf_mispred_q <= perf_mispred_q + 32'd1;
      end
    end
  end

  assign bus.perf_commits  = perf_commits_q;
  assign bus.perf_branches = perf_branches_q;
  assign bus.perf_mispred  = perf_mispred_q;
`endif

endmodule

// File: tb/tb_rob_multiport.sv
// Scoreboard bench for rob_multiport: a queue-based ROB model predicts each retirement,
// a monitor compares every commit pulse; directed cases cover the documented scenarios.
module tb_rob_multiport;
  import rob_multiport_pkg::*;

  localparam int unsigned D  = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned NW = 2;
  localparam int unsigned NQ = 2;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  rob_multiport_if #(.IDX_W(IW), .WB_PORTS(NW), .QRY_PORTS(NQ)) bus ();

  rob_multiport #(.DEPTH(D), .IDX_W(IW), .WB_PORTS(NW), .QRY_PORTS(NQ)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  int vec  = 0;
  int miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order queue of in-flight ids plus per-id fields.
  int unsigned mq[$];
  logic [2:0]  m_cls [D];
  logic [4:0]  m_rd  [D];
  logic [31:0] m_pc  [D];
  logic [31:0] m_imm [D];
  logic [31:0] m_res [D];
  bit          m_isc [D];
  bit          m_pred[D];
  bit          m_done[D];
  int unsigned m_tail  = 0;
  bit          m_flush = 1'b0;

  typedef struct {
    bit          cv, st, bv, jv, fl, tk, corr;
    logic [4:0]  rd;
    logic [3:0]  id;
    logic [31:0] val, bpc, rpc;
  } exp_t;
  exp_t expq[$];

  function automatic bit in_flight(input int unsigned id);
    foreach (mq[i]) if (mq[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  // Advances the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    bit [D-1:0]  busy_pre;
    bit          do_ret, ready;
    int unsigned h, id;
    exp_t        e;
    logic [31:0] fall;
    if (rst || (rdy && m_flush)) begin
      mq.delete();
      m_tail  = 0;
      m_flush = 1'b0;
      return;
    end
    if (!rdy) return;
    ready    = mq.size() < D;
    busy_pre = '0;
    foreach (mq[i]) busy_pre[mq[i]] = 1'b1;
    do_ret = (mq.size() > 0) && m_done[mq[0]];
    if (do_ret) begin
      h    = mq[0];
      e    = '{default: 0};
      e.id = h[3:0];
      fall = m_pc[h] + (m_isc[h] ? 32'd2 : 32'd4);
      case (m_cls[h])
        3'd0, 3'd1: begin e.cv = 1; e.rd = m_rd[h]; e.val = m_res[h]; end
        3'd2: e.st = 1;
        3'd3: begin
          e.bv   = 1;
          e.tk   = m_res[h][0];
          e.corr = (m_res[h][0] == m_pred[h]);
          e.bpc  = m_pc[h];
          if (!e.corr) begin
            e.fl    = 1;
            e.rpc   = e.tk ? m_pc[h] + m_imm[h] : fall;
            m_flush = 1'b1;
          end
        end
        default: begin
          e.cv = 1; e.rd = m_rd[h]; e.val = fall; e.jv = 1;
          e.rpc = {m_res[h][31:1], 1'b0};
        end
      endcase
      expq.push_back(e);
    end
    for (int k = 0; k < NW; k++) begin
      id = bus.wb_id[k*IW +: IW];
      if (bus.wb_valid[k] && busy_pre[id]) begin
        m_done[id] = 1'b1;
        m_res[id]  = bus.wb_val[k*32 +: 32];
      end
    end
    if (do_ret) void'(mq.pop_front());
    if (bus.iss_valid && ready) begin
      m_cls[m_tail]  = bus.iss_cls;
      m_rd[m_tail]   = bus.iss_rd;
      m_pc[m_tail]   = bus.iss_pc;
      m_imm[m_tail]  = bus.iss_imm;
      m_isc[m_tail]  = bus.iss_is_c;
      m_pred[m_tail] = bus.iss_pred;
      m_done[m_tail] = 1'b0;
      mq.push_back(m_tail);
      m_tail = (m_tail + 1) % D;
    end
  endtask

  // Checks state-derived outputs, steps the model, then crosses one rising edge.
  task automatic step();
    bit          exp_ready, exp_qr;
    int unsigned qid;
    #1;
    if (!rst) begin
      exp_ready = !m_flush && (mq.size() < D);
      check("iss_ready", bus.iss_ready, exp_ready);
      check("count_out", bus.count_out, mq.size());
      check("head_out", bus.head_out, (m_tail + D - mq.size()) % D);
      if (rdy && bus.iss_valid && exp_ready) check("iss_id", bus.iss_id, m_tail);
      for (int p = 0; p < NQ; p++) begin
        qid    = bus.qry_id[p*IW +: IW];
        exp_qr = in_flight(qid) && m_done[qid];
        check("qry_ready", bus.qry_ready[p], exp_qr);
        if (exp_qr) check("qry_val", bus.qry_val[p*32 +: 32], m_res[qid]);
      end
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every fresh commit pulse is matched against the oldest predicted retirement.
  bit   mon_en;
  exp_t mon_e;
  always @(posedge clk) begin
    mon_en = rdy && !rst;
    #1;
    if (mon_en && (bus.cmt_valid || bus.st_cmt || bus.br_valid || bus.jalr_valid
                   || bus.flush_out)) begin
      if (expq.size() == 0) begin
        check("unexpected commit pulse", 32'd1, 32'd0);
      end else begin
        mon_e = expq.pop_front();
        check("cmt_valid", bus.cmt_valid, mon_e.cv);
        check("st_cmt", bus.st_cmt, mon_e.st);
        check("br_valid", bus.br_valid, mon_e.bv);
        check("jalr_valid", bus.jalr_valid, mon_e.jv);
        check("flush_out", bus.flush_out, mon_e.fl);
        if (mon_e.cv) begin
          check("cmt_rd", bus.cmt_rd, mon_e.rd);
          check("cmt_id", bus.cmt_id, mon_e.id);
          check("cmt_val", bus.cmt_val, mon_e.val);
        end
        if (mon_e.bv) begin
          check("br_taken", bus.br_taken, mon_e.tk);
          check("br_correct", bus.br_correct, mon_e.corr);
          check("br_pc", bus.br_pc, mon_e.bpc);
        end
        if (mon_e.fl || mon_e.jv) check("redirect_pc", bus.redirect_pc, mon_e.rpc);
      end
    end
  end

  task automatic idle_inputs();
    bus.iss_valid = 1'b0;
    bus.iss_cls   = '0;
    bus.iss_rd    = '0;
    bus.iss_pc    = '0;
    bus.iss_is_c  = 1'b0;
    bus.iss_imm   = '0;
    bus.iss_pred  = 1'b0;
    bus.wb_valid  = '0;
    bus.wb_id     = '0;
    bus.wb_val    = '0;
    bus.qry_id    = '0;
  endtask

  task automatic issue_in(input logic [2:0] cls, input logic [4:0] rd, input logic [31:0] pc,
                          input bit isc, input logic [31:0] imm, input bit pred);
    bus.iss_valid = 1'b1;
    bus.iss_cls   = cls;
    bus.iss_rd    = rd;
    bus.iss_pc    = pc;
    bus.iss_is_c  = isc;
    bus.iss_imm   = imm;
    bus.iss_pred  = pred;
  endtask

  task automatic wb_in(input int k, input int unsigned id, input logic [31:0] v);
    bus.wb_valid[k]          = 1'b1;
    bus.wb_id[k*IW +: IW]    = id[IW-1:0];
    bus.wb_val[k*32 +: 32]   = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned id;
    do_reset();
    check("reset cmt_valid", bus.cmt_valid, 0);
    check("reset flush_out", bus.flush_out, 0);
    check("reset br_valid", bus.br_valid, 0);
    check("reset st_cmt", bus.st_cmt, 0);
    check("reset jalr_valid", bus.jalr_valid, 0);

    // Out-of-order writeback, in-order commit; done on cycle N shows on N+2.
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); issue_in(CLS_ALU, 5'(i + 1), 32'h1000 + 32'(4 * i), 0, 0, 0); step();
    end
    idle_inputs(); wb_in(0, 2, 32'h30); step();
    idle_inputs(); wb_in(1, 0, 32'h10); step();
    check("ooo no early commit", bus.cmt_valid, 0);
    idle_inputs(); wb_in(0, 1, 32'h20); step();
    check("ooo cmt0 valid", bus.cmt_valid, 1);
    check("ooo cmt0 val", bus.cmt_val, 32'h10);
    idle_inputs(); step();
    check("ooo cmt1 val", bus.cmt_val, 32'h20);
    idle_inputs(); step();
    check("ooo cmt2 val", bus.cmt_val, 32'h30);
    check("ooo cmt2 id", bus.cmt_id, 2);
    idle_inputs(); step();
    check("ooo quiet after", bus.cmt_valid, 0);

    // Fill to capacity, reject the extra issue, then wrap the tail.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle_inputs(); issue_in(CLS_ALU, 5'(i), 32'h2000 + 32'(4 * i), 0, 0, 0); step();
    end
    check("full iss_ready", bus.iss_ready, 0);
    check("full count_out", bus.count_out, 16);
    idle_inputs(); issue_in(CLS_ALU, 5'd31, 32'h3000, 0, 0, 0); step();
    check("full extra ignored", bus.count_out, 16);
    idle_inputs(); wb_in(0, 0, 32'h55); step();
    idle_inputs(); step();
    check("after retire iss_ready", bus.iss_ready, 1);
    idle_inputs(); issue_in(CLS_LOAD, 5'd9, 32'h3004, 0, 0, 0);
    #1;
    check("wrap iss_id", bus.iss_id, 0);
    step();
    check("wrap count_out", bus.count_out, 16);

    // Mispredicted taken branch.
    do_reset();
    idle_inputs(); issue_in(CLS_BRANCH, 5'd0, 32'h100, 0, 32'h40, 0); step();
    idle_inputs(); wb_in(0, 0, 32'h1); step();
    idle_inputs(); step();
    check("br br_valid", bus.br_valid, 1);
    check("br br_correct", bus.br_correct, 0);
    check("br flush_out", bus.flush_out, 1);
    check("br redirect_pc", bus.redirect_pc, 32'h140);
    idle_inputs(); step();
    check("br count after flush", bus.count_out, 0);
    check("br flush drops", bus.flush_out, 0);

    // Compressed JALR.
    do_reset();
    idle_inputs(); issue_in(CLS_JALR, 5'd1, 32'h200, 1, 32'h0, 0); step();
    idle_inputs(); wb_in(0, 0, 32'h305); step();
    idle_inputs(); step();
    check("jalr cmt_val", bus.cmt_val, 32'h202);
    check("jalr jalr_valid", bus.jalr_valid, 1);
    check("jalr redirect_pc", bus.redirect_pc, 32'h304);
    check("jalr no flush", bus.flush_out, 0);

    // Two channels on one id; same-cycle writeback is not forwarded.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle_inputs(); issue_in(CLS_ALU, 5'(i), 32'h400 + 32'(4 * i), 0, 0, 0); step();
    end
    idle_inputs(); wb_in(0, 5, 32'hA); wb_in(1, 5, 32'hB); step();
    idle_inputs(); wb_in(0, 4, 32'hC);
    bus.qry_id = {4'd4, 4'd5};
    #1;
    check("dual wb qry_ready", bus.qry_ready[0], 1);
    check("dual wb qry_val", bus.qry_val[31:0], 32'hB);
    check("no wb bypass", bus.qry_ready[1], 0);
    step();

    // Stall with rdy low while a commit pulse is showing.
    do_reset();
    idle_inputs(); issue_in(CLS_ALU, 5'd7, 32'h500, 0, 0, 0); step();
    idle_inputs(); wb_in(0, 0, 32'h77); step();
    idle_inputs(); step();
    for (int i = 0; i < 3; i++) begin
      rdy = 1'b0;
      idle_inputs(); issue_in(CLS_ALU, 5'd8, 32'h504, 0, 0, 0); wb_in(1, 1, 32'h99); step();
      check("stall cmt_valid", bus.cmt_valid, 1);
      check("stall cmt_val", bus.cmt_val, 32'h77);
      check("stall cmt_rd", bus.cmt_rd, 7);
      check("stall head_out", bus.head_out, 1);
      check("stall count_out", bus.count_out, 0);
    end
    rdy = 1'b1;
    idle_inputs(); step();
    check("stall release quiet", bus.cmt_valid, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      rdy = ($urandom % 8) != 0;
      if ($urandom % 2 == 0) begin
        issue_in(3'($urandom_range(4, 0)), 5'($urandom), $urandom & ~32'd1, 1'($urandom),
                 $urandom % 1024, 1'($urandom));
      end
      for (int k = 0; k < NW; k++) begin
        if ($urandom % 10 < 7) begin
          if (mq.size() > 0 && $urandom % 4 != 0) id = mq[$urandom % mq.size()];
          else id = $urandom % D;
          wb_in(k, id, $urandom);
        end
      end
      bus.qry_id = 8'($urandom);
      step();
    end
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); step();
    end
    check("scoreboard drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
